teclado_fsm1: RTL
=================

# teclado_fsm1

Keypad front end feeding the temperature-entry stage (`FSM2` inside `bloquedos`). It scans a 4x4 matrix keypad one column at a time and debounces presses. Each accepted key becomes a 4-bit code on `tvalida`, with a one-cycle `esnumero` strobe for digits 0-9, which `bloquedos` consumes directly. Acceptance is gated by the `enable_FSM1` handshake that `bloquedos` returns.

## Interface
- SCAN_DIV, 50000: clocks per scan tick (column dwell); minimum 4
- DEB_MAX, 8: consecutive identical tick samples needed to accept a press or a release; minimum 1
- CLK  input  1  system clock, all logic on rising edge
- Reset  input  1  asynchronous, active-high; clears every register
- fila  input  4  keypad rows, active-low, pulled up externally, asynchronous to CLK
- enable_FSM1  input  1  from `bloquedos`; 1 = keys may be delivered
- columna  output  4  column drive, active-low, exactly one bit low at all times
- tvalida  output  4  code of last delivered key, held until the next delivery
- esnumero  output  1  one-cycle strobe: delivered key is a digit (`tvalida` ≤ 9)
- tecla  output  1  one-cycle strobe: any key delivered (digit or not)

## Operation
- `fila` passes through a 2-flop synchronizer (`fila_s`) before any use.
- Tick: a counter counts 0..SCAN_DIV-1 and wraps. The tick is the cycle where the count equals SCAN_DIV-1. All samples below are `fila_s` on a tick cycle.
- Key map, row r (0 = top) × column c (0 = left):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
- Codes: digits → 0-9; A-D → 10-13; * → 14; # → 15.
- States: SCAN, DEBOUNCE, EMIT, RELEASE.
- SCAN:
  - If the tick sample has no row low, advance the column index (3 wraps to 0).
  - If any row is low, latch the column and the lowest-index low row, clear the debounce counter, and go to DEBOUNCE. The column is not advanced.
- DEBOUNCE:
  - Column frozen.
  - Each tick with the latched row low increments the counter.
  - When the counter reaches DEB_MAX, go to EMIT.
  - A tick with the latched row high returns to SCAN and advances the column.
  - Other rows are ignored.
- EMIT, one cycle:
  - If `enable_FSM1` = 1: load `tvalida` with the code, pulse `tecla`, and pulse `esnumero` iff code ≤ 9.
  - If `enable_FSM1` = 0: the key is discarded; `tvalida` and both strobes are unchanged.
  - Always go to RELEASE with the counter cleared.
- RELEASE:
  - Column frozen.
  - Each tick with the latched row high increments the counter; a tick with the row low clears it.
  - When the counter reaches DEB_MAX, return to SCAN and advance the column.
- A held key is delivered exactly once. Auto-repeat is not supported.
- The tick counter free-runs in all states and is never reset by a state change.
- `enable_FSM1` is sampled only in EMIT.

## Timing
- Reset values: state SCAN, column index 0, `columna` = 4'b1110, `tvalida` = 4'h0, `esnumero` = 0, `tecla` = 0, tick and debounce counters 0.
- Reset mid-press: return to SCAN. A key still held after reset is re-detected and delivered once.
- `columna` changes only on the edge following a tick. It then holds for SCAN_DIV cycles; SCAN_DIV ≥ 4 covers synchronizer delay plus row settling.
- Latency from the first detecting tick sample to the strobe: DEB_MAX further ticks, then 1 clock (EMIT cycle).
- `tvalida`, `esnumero` and `tecla` change on the same edge. The strobes are high for exactly one cycle; `tvalida` is valid from that cycle onward.
- Minimum spacing between two deliveries: (2·DEB_MAX + 1) ticks.
- Simultaneous keys in the same column: the lowest row wins.
- Simultaneous keys in different columns: the first column scanned wins; the other key is seen only after release.

## Test plan
(All scenarios use SCAN_DIV = 4, DEB_MAX = 3.)
- Reset → `columna` = 1110, `tvalida` = 0, no strobes; with no key, `columna` cycles 1110→1101→1011→0111→1110, changing every 4 clocks.
- Hold key 5 (r1, c1) with `enable_FSM1` = 1 → one `tecla` + `esnumero` pulse, `tvalida` = 5. Pulse occurs 3 ticks + 1 clock after the detecting tick. No second pulse while held.
- Press # (r3, c2) with `enable_FSM1` = 1 → `tecla` pulse, `esnumero` stays 0, `tvalida` = 15.
- Press 7 with `enable_FSM1` = 0 → no strobes, `tvalida` keeps its previous value. Scanning resumes after release.
- Bounce: key 2 low for 2 ticks, high for 1, low for 1, then released → no delivery. Scanning resumes at the next column.
- Hold 9; assert Reset for 2 clocks mid-DEBOUNCE → outputs return to reset values. `9` is delivered exactly once after reset while still held.

Source files
------------

// File: rtl/teclado_fsm1.sv
// ---------------------------------------------------------------------------
// teclado_fsm1 : 4x4 matrix keypad scanner and debouncer
//
// Drives one keypad column low at a time, samples the (active-low) rows on a
// slow scan tick, and debounces presses. Each accepted key is delivered once
// as a 4-bit code on tvalida, with strobes tecla (any key) and esnumero
// (digit 0-9). Delivery is gated by enable_FSM1 from the downstream
// temperature-entry stage.
//
// Parameters
//   SCAN_DIV    clocks per scan tick (column dwell), >= 4
//   DEB_MAX     consecutive identical tick samples to accept press/release
//
// Ports
//   CLK          system clock, rising edge
//   Reset        asynchronous, active-high
//   fila[3:0]    keypad rows, active-low, asynchronous to CLK
//   enable_FSM1  1 = a debounced key may be delivered
//   columna[3:0] column drive, active-low, exactly one bit low
//   tvalida[3:0] code of the last delivered key
//   esnumero     one-cycle strobe, delivered key is a digit
//   tecla        one-cycle strobe, any key delivered
// ---------------------------------------------------------------------------
module teclado_fsm1 #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_MAX  = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] fila,
  input  logic       enable_FSM1,
  output logic [3:0] columna,
  output logic [3:0] tvalida,
  output logic       esnumero,
  output logic       tecla
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = $clog2(DEB_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_TOP   = DEB_W'(DEB_MAX);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Lowest-index row that is pulled low; only called when some row is low.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] r;
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else               r = 2'd3;
    return r;
  endfunction

  // Physical key position to delivered code.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] row,
                                          input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Registered state
  state_t            state_q,    state_d;
  logic [3:0]        fila_meta_q, fila_meta_d;
  logic [3:0]        fila_s_q,   fila_s_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
  logic [1:0]        col_idx_q,  col_idx_d;
  logic [1:0]        row_q,      row_d;
  logic [3:0]        columna_q,  columna_d;
  logic [3:0]        tvalida_q,  tvalida_d;
  logic              esnumero_q, esnumero_d;
  logic              tecla_q,    tecla_d;

  logic              tick;
  logic              row_low;
  logic [3:0]        code;

  assign tick    = (tick_cnt_q == TICK_LAST);
  // Level of the latched row; meaningful in DEBOUNCE/RELEASE only.
  assign row_low = ~fila_s_q[row_q];
  assign code    = key_code(row_q, col_idx_q);

  always_comb begin
    state_d     = state_q;
    fila_meta_d = fila;
    fila_s_d    = fila_meta_q;
    deb_cnt_d   = deb_cnt_q;
    col_idx_d   = col_idx_q;
    row_d       = row_q;
    tvalida_d   = tvalida_q;
    esnumero_d  = 1'b0;
    tecla_d     = 1'b0;

    // Free-running scan divider, independent of the FSM.
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (fila_s_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            // Column stays put; the current column is the latched one.
            row_d     = low_row(fila_s_q);
            deb_cnt_d = '0;
            state_d   = ST_DEBOUNCE;
          end
        end
      end

      ST_DEBOUNCE: begin
        if (tick) begin
          if (row_low) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
            if (deb_cnt_q + 1'b1 == DEB_TOP) begin
              state_d = ST_EMIT;
            end
          end else begin
            // Bounce: give up on this key and move on to the next column.
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
      end

      ST_EMIT: begin
        if (enable_FSM1) begin
          tvalida_d  = code;
          tecla_d    = 1'b1;
          esnumero_d = (code <= 4'd9);
        end
        deb_cnt_d = '0;
        state_d   = ST_RELEASE;
      end

      default: begin // ST_RELEASE
        if (tick) begin
          if (!row_low) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
            if (deb_cnt_q + 1'b1 == DEB_TOP) begin
              deb_cnt_d = '0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = ST_SCAN;
            end
          end else begin
            deb_cnt_d = '0;
          end
        end
      end
    endcase

    // Column drive registered from the next index so it moves on the
    // edge following a tick and never glitches.
    columna_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_SCAN;
      fila_meta_q <= 4'hF;
      fila_s_q    <= 4'hF;
      tick_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      col_idx_q   <= 2'd0;
      row_q       <= 2'd0;
      columna_q   <= 4'b1110;
      tvalida_q   <= 4'h0;
      esnumero_q  <= 1'b0;
      tecla_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fila_meta_q <= fila_meta_d;
      fila_s_q    <= fila_s_d;
      tick_cnt_q  <= tick_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      col_idx_q   <= col_idx_d;
      row_q       <= row_d;
      columna_q   <= columna_d;
      tvalida_q   <= tvalida_d;
      esnumero_q  <= esnumero_d;
      tecla_q     <= tecla_d;
    end
  end

  assign columna  = columna_q;
  assign tvalida  = tvalida_q;
  assign esnumero = esnumero_q;
  assign tecla    = tecla_q;

endmodule
